out_display_driver: RTL

Output display stage for the SAP-2 computer. Sits directly downstream of the OUT register: it captures the value written by an OUT instruction, converts it to decimal with a sequential double-dabble engine, and drives a 4-digit multiplexed common-anode 7-segment display. Conversion runs independently of the CPU; the CPU never stalls on this block.

---
 rtl/out_display_driver.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/out_display_driver.sv
// out_display_driver
//
// SAP-2 output display stage. Captures each value written by an OUT
// instruction and converts it to decimal with a sequential double-dabble
// engine (one iteration per clock). The result drives a 4-digit multiplexed
// common-anode 7-segment display. The CPU never waits on this block: a load
// that arrives during a conversion is held in a 1-deep pending register
// (last write wins) and converted right after the current commit.
//
// Build option:
//   SIGNED_DISPLAY_EN  out_val is two's complement; the magnitude is
//                      converted and digit 3 shows a minus sign for negatives.
//                      Without it, out_val is unsigned and neg is tied 0.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous, active-high reset
//   out_load  one-cycle strobe, same cycle the OUT register loads
//   out_val   value written to the OUT register (sampled when out_load=1)
//   busy      conversion in progress or pending
//   bcd       committed digits {hundreds, tens, ones}
//   neg       committed sign (1 = negative)
//   seg       active-low segments {g,f,e,d,c,b,a}, registered
//   an        active-low digit enables, an[0]=ones .. an[3]=sign, registered

module out_display_driver #(
  parameter int DATA_WIDTH    = 8,
  parameter int REFRESH_TICKS = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  out_load,
  input  logic [DATA_WIDTH-1:0] out_val,
  output logic                  busy,
  output logic [11:0]           bcd,
  output logic                  neg,
  output logic [6:0]            seg,
  output logic [3:0]            an
);

  localparam int ITER_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int CNT_W  = (REFRESH_TICKS > 2) ? $clog2(REFRESH_TICKS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [11:0]           acc_q, acc_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [11:0]           bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            an_q, an_d;

  logic                  start;
  logic [DATA_WIDTH-1:0] src_val;
  logic [11:0]           dab_adj;
  logic                  neg_int;

`ifdef SIGNED_DISPLAY_EN
  logic sign_q, sign_d;
  logic neg_q, neg_d;
  assign neg_int = neg_q;
`else
  assign neg_int = 1'b0;
`endif

  // Magnitude of the captured value. In the signed build 0x80 negates to
  // itself, which read as unsigned is the required 128.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
`ifdef SIGNED_DISPLAY_EN
    magnitude = v[DATA_WIDTH-1] ? (~v + DATA_WIDTH'(1)) : v;
`else
    magnitude = v;
`endif
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h40;
      4'd1:    seg_enc = 7'h79;
      4'd2:    seg_enc = 7'h24;
      4'd3:    seg_enc = 7'h30;
      4'd4:    seg_enc = 7'h19;
      4'd5:    seg_enc = 7'h12;
      4'd6:    seg_enc = 7'h02;
      4'd7:    seg_enc = 7'h78;
      4'd8:    seg_enc = 7'h00;
      4'd9:    seg_enc = 7'h10;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: each nibble >= 5 gets +3 before the shift so
  // that it carries correctly into the next decimal digit.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dab
      assign dab_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ?
                                  (acc_q[gi*4 +: 4] + 4'd3) : acc_q[gi*4 +: 4];
    end
  endgenerate

  // Conversion FSM and pending register
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    iter_d       = iter_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    bcd_d        = bcd_q;
    start        = 1'b0;
    src_val      = out_val;
`ifdef SIGNED_DISPLAY_EN
    sign_d       = sign_q;
    neg_d        = neg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (out_load) begin
          start   = 1'b1;
          src_val = out_val;
        end
      end
      S_CONVERT: begin
        {acc_d, shift_d} = {dab_adj[10:0], shift_q, 1'b0};
        iter_d           = iter_q + 1'b1;
        if (iter_q == ITER_W'(DATA_WIDTH - 1)) begin
          state_d = S_COMMIT;
        end
        // A load mid-conversion is parked; a later one overwrites it.
        if (out_load) begin
          pend_d       = out_val;
          pend_valid_d = 1'b1;
        end
      end
      S_COMMIT: begin
        bcd_d = acc_q;
`ifdef SIGNED_DISPLAY_EN
        neg_d = sign_q;
`endif
        // A load arriving on the commit cycle is newer than anything pending,
        // so it is started directly and the pending slot is emptied.
        if (out_load) begin
          start        = 1'b1;
          src_val      = out_val;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          start        = 1'b1;
          src_val      = pend_q;
          pend_valid_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      shift_d = magnitude(src_val);
      acc_d   = '0;
      iter_d  = '0;
      state_d = S_CONVERT;
`ifdef SIGNED_DISPLAY_EN
      sign_d  = src_val[DATA_WIDTH-1];
`endif
    end
  end

  // Display scan; runs independently of the conversion FSM.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_TICKS - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    an_d  = ~(4'b0001 << idx_q);
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: seg_d = seg_enc(bcd_q[3:0]);
      2'd1: seg_d = (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) ?
                    SEG_BLANK : seg_enc(bcd_q[7:4]);
      2'd2: seg_d = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg_enc(bcd_q[11:8]);
      2'd3: seg_d = neg_int ? SEG_MINUS : SEG_BLANK;
      default: seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      acc_q        <= '0;
      iter_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'b1111;
`ifdef SIGNED_DISPLAY_EN
      sign_q       <= 1'b0;
      neg_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      iter_q       <= iter_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
`ifdef SIGNED_DISPLAY_EN
      sign_q       <= sign_d;
      neg_q        <= neg_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE) | pend_valid_q;
  assign bcd  = bcd_q;
  assign neg  = neg_int;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule
